// File: rtl/nativefifo2axis_if.sv
// AXI-stream master bundle for the native-FIFO-to-AXIS bridge.
// The tlast member exists only when NATIVEFIFO2AXIS_TLAST_EN is defined.

interface nativefifo2axis_if #(
  parameter int DW = 24
);
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
`ifdef NATIVEFIFO2AXIS_TLAST_EN
  logic          tlast;
`endif

  modport master (
    output tdata,
    output tvalid,
`ifdef NATIVEFIFO2AXIS_TLAST_EN
    output tlast,
`endif
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
`ifdef NATIVEFIFO2AXIS_TLAST_EN
    input  tlast,
`endif
    output tready
  );
endinterface

// File: rtl/nativefifo2axis.sv
// Native FIFO (read latency 1) to AXI-stream bridge with a 3-entry output buffer.
// Optional frame marker m_axis.tlast is built when NATIVEFIFO2AXIS_TLAST_EN is defined.

module nativefifo2axis #(
  parameter int DW        = 24,
  parameter int FRAME_LEN = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     fifo_dout,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  nativefifo2axis_if.master m_axis
);

  if (FRAME_LEN < 2) begin : g_bad_frame_len
    $error("nativefifo2axis: FRAME_LEN must be >= 2");
  end

  logic [1:0]    occ_r;
  logic [1:0]    occ_pop_s;
  logic [1:0]    occ_nxt_s;
  logic          inflight_r;
  logic          tvalid_r;
  logic          pop_s;
  logic [2:0]    load_s;
  logic [DW-1:0] buf_r     [3];
  logic [DW-1:0] buf_nxt_s [3];

  // Reads are throttled only by registered state, so tready never reaches fifo_rd
  assign load_s  = {1'b0, occ_r} + {2'b00, inflight_r};
  assign fifo_rd = !rst && !fifo_empty && (load_s < 3'd3);
  assign pop_s   = tvalid_r && m_axis.tready;

  assign m_axis.tdata  = buf_r[0];
  assign m_axis.tvalid = tvalid_r;

  // Next buffer contents: pop the head first, then append the captured word at the new tail
  always_comb begin
    occ_pop_s = occ_r - {1'b0, pop_s};
    buf_nxt_s = buf_r;
    if (pop_s) begin
      buf_nxt_s[0] = buf_r[1];
      buf_nxt_s[1] = buf_r[2];
    end else begin
      buf_nxt_s[0] = buf_r[0];
      buf_nxt_s[1] = buf_r[1];
    end
    if (inflight_r) begin
      occ_nxt_s = occ_pop_s + 2'd1;
      case (occ_pop_s)
        2'd0:    buf_nxt_s[0] = fifo_dout;
        2'd1:    buf_nxt_s[1] = fifo_dout;
        2'd2:    buf_nxt_s[2] = fifo_dout;
        default: ;
      endcase
    end else begin
      occ_nxt_s = occ_pop_s;
    end
  end

  // Buffer, occupancy and in-flight state; a word returning during reset is dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_r      <= 2'd0;
      inflight_r <= 1'b0;
      tvalid_r   <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        buf_r[i] <= '0;
      end
    end else begin
      occ_r      <= occ_nxt_s;
      inflight_r <= fifo_rd;
      tvalid_r   <= (occ_nxt_s != 2'd0);
      buf_r      <= buf_nxt_s;
    end
  end

`ifdef NATIVEFIFO2AXIS_TLAST_EN
  localparam int            CW        = $clog2(FRAME_LEN);
  localparam logic [CW-1:0] LAST_BEAT = CW'(FRAME_LEN - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic          tlast_r;

  assign m_axis.tlast = tlast_r;

  // Beat counter advances on each handshake and wraps after the last beat of a frame
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (pop_s) begin
      if (cnt_r == LAST_BEAT) begin
        cnt_nxt_s = '0;
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // tlast is registered from next-state values so it stays aligned with tdata/tvalid
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= '0;
      tlast_r <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      tlast_r <= (occ_nxt_s != 2'd0) && (cnt_nxt_s == LAST_BEAT);
    end
  end
`endif

endmodule
